ysyx_23060025_axi_rd_master: RTL and testbench

//   Read-channel initiator for the core's memory-mapped read bus (AR + R channels).

---
 rtl/ysyx_23060025_axi_rd_master.sv | 167 ++++++++++++++++
 tb/tb_ysyx_23060025_axi_rd_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_axi_rd_master.sv
// ============================================================================
// Module      : ysyx_23060025_axi_rd_master
// Description : Single-outstanding AR/R read initiator. Returns one response
//               (first-beat data, merged status, latency) per request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060025_axi_rd_master #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int LAT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_LEN-1:0] rsp_data_o,
    output logic [1:0]          rsp_resp_o,
    output logic [LAT_W-1:0]    rsp_lat_o,
    output logic [ADDR_LEN-1:0] addr_r_addr_o,
    output logic                addr_r_valid_o,
    input  logic                addr_r_ready_i,
    input  logic [DATA_LEN-1:0] r_data_i,
    input  logic [1:0]          r_resp_i,
    input  logic                r_valid_i,
    input  logic                r_last_i,
    output logic                r_ready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;

    state_t              state_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [LAT_W-1:0]    lat_q;
    logic [1:0]          acc_resp_q;
    logic                err_q;
    logic                first_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                rsp_valid_q;
    logic [DATA_LEN-1:0] rsp_data_q;
    logic [1:0]          rsp_resp_q;
    logic [LAT_W-1:0]    rsp_lat_q;

    logic [LAT_W-1:0]    lat_d;
    logic [1:0]          acc_resp_d;
    logic [1:0]          final_resp_d;

    // DECERR outranks SLVERR; OKAY/EXOKAY carry no error weight
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] sa;
        logic [1:0] sb;
        sa = a[1] ? (a[0] ? 2'd3 : 2'd2) : 2'd0;
        sb = b[1] ? (b[0] ? 2'd3 : 2'd2) : 2'd0;
        return (sb > sa) ? b : a;
    endfunction

    always_comb begin
        lat_d        = (lat_q == {LAT_W{1'b1}}) ? lat_q : lat_q + 1'b1;
        acc_resp_d   = worst(acc_resp_q, r_resp_i);
        final_resp_d = C_OKAY;
        if (acc_resp_d[1]) begin
            final_resp_d = acc_resp_d;
        end else if (err_q) begin
            final_resp_d = C_SLVERR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            lat_q       <= '0;
            acc_resp_q  <= C_OKAY;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= C_OKAY;
            rsp_lat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_i;
                        lat_q      <= '0;
                        acc_resp_q <= C_OKAY;
                        err_q      <= 1'b0;
                        first_q    <= 1'b1;
                        rsp_data_q <= '0;
                        rsp_lat_q  <= '0;
                        if (req_addr_i[1:0] != 2'b00) begin
                            rsp_resp_q  <= C_SLVERR;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            rsp_resp_q <= C_OKAY;
                            arvalid_q  <= 1'b1;
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    lat_q <= lat_d;
                    if (addr_r_ready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    lat_q <= lat_d;
                    if (r_valid_i) begin
                        first_q    <= 1'b0;
                        acc_resp_q <= acc_resp_d;
                        if (first_q) begin
                            rsp_data_q <= r_data_i;
                        end
                        if (r_last_i) begin
                            rready_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_lat_q   <= lat_d;
                            rsp_resp_q  <= final_resp_d;
                            state_q     <= S_RESP;
                        end else begin
                            // a multi-beat reply to a single-beat request is an error
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state_q == S_IDLE) && !reset;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_resp_o     = rsp_resp_q;
    assign rsp_lat_o      = rsp_lat_q;
    assign addr_r_addr_o  = addr_q;
    assign addr_r_valid_o = arvalid_q;
    assign r_ready_o      = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060025_axi_rd_master.sv
// ============================================================================
// Module      : tb_ysyx_23060025_axi_rd_master
// Description : Directed self-checking bench for the AR/R read initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060025_axi_rd_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_resp_o;
    logic [15:0] rsp_lat_o;
    logic [31:0] addr_r_addr_o;
    logic        addr_r_valid_o;
    logic        addr_r_ready_i;
    logic [31:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_valid_i;
    logic        r_last_i;
    logic        r_ready_o;

    int checks   = 0;
    int failures = 0;

    ysyx_23060025_axi_rd_master #(
        .ADDR_LEN(32),
        .DATA_LEN(32),
        .LAT_W   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_resp_o    (rsp_resp_o),
        .rsp_lat_o     (rsp_lat_o),
        .addr_r_addr_o (addr_r_addr_o),
        .addr_r_valid_o(addr_r_valid_o),
        .addr_r_ready_i(addr_r_ready_i),
        .r_data_i      (r_data_i),
        .r_resp_i      (r_resp_i),
        .r_valid_i     (r_valid_i),
        .r_last_i      (r_last_i),
        .r_ready_o     (r_ready_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] rs, input logic last);
        r_valid_i = 1'b1;
        r_data_i  = d;
        r_resp_i  = rs;
        r_last_i  = last;
        step();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        req_valid_i    = 1'b0;
        req_addr_i     = '0;
        rsp_ready_i    = 1'b0;
        addr_r_ready_i = 1'b0;
        r_data_i       = '0;
        r_resp_i       = 2'b00;
        r_valid_i      = 1'b0;
        r_last_i       = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_arvalid", addr_r_valid_o, 0);
        chk("rst_rready", r_ready_o, 0);
        chk("rst_outs", {rsp_data_o, rsp_resp_o, rsp_lat_o, addr_r_addr_o}, 0);
        reset = 1'b0;
        #1;
        chk("rel_req_ready", req_ready_o, 1);

        // Reset while waiting for read data
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0040; addr_r_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        addr_r_ready_i = 1'b0;
        chk("t1_rready", r_ready_o, 1);
        r_valid_i = 1'b1; r_last_i = 1'b1; r_data_i = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        chk("t1_rst_rready", r_ready_o, 0);
        chk("t1_rst_outs", {rsp_valid_o, addr_r_valid_o, req_ready_o, rsp_data_o, rsp_lat_o, addr_r_addr_o}, 0);
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0;
        reset = 1'b0;
        step();
        chk("t1_req_ready", req_ready_o, 1);
        step();
        chk("t1_no_rsp", rsp_valid_o, 0);

        // CLINT-style slave
        req_valid_i = 1'b1; req_addr_i = 32'h0200_BFF8; addr_r_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        chk("t2_arvalid", addr_r_valid_o, 1);
        chk("t2_araddr", addr_r_addr_o, 32'h0200_BFF8);
        chk("t2_req_busy", req_ready_o, 0);
        step();
        addr_r_ready_i = 1'b0;
        chk("t2_rready", {addr_r_valid_o, r_ready_o}, 2'b01);
        beat(32'h1234_5678, 2'b00, 1'b1);
        chk("t2_rsp_valid", rsp_valid_o, 1);
        chk("t2_rsp", {rsp_data_o, rsp_resp_o, rsp_lat_o}, {32'h1234_5678, 2'b00, 16'd2});
        rsp_ready_i = 1'b1;
        #1;
        chk("t2_hs_req_ready", req_ready_o, 0);
        step();
        rsp_ready_i = 1'b0;
        chk("t2_idle", {rsp_valid_o, req_ready_o}, 2'b01);

        // AR stall for 5 cycles
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0010;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_ar", {addr_r_valid_o, addr_r_addr_o}, {1'b1, 32'h8000_0010});
            step();
        end
        addr_r_ready_i = 1'b1;
        chk("t3_ar_hs", {addr_r_valid_o, addr_r_addr_o}, {1'b1, 32'h8000_0010});
        step();
        addr_r_ready_i = 1'b0;
        beat(32'hCAFE_F00D, 2'b00, 1'b1);
        chk("t3_rsp", {rsp_valid_o, rsp_data_o, rsp_resp_o, rsp_lat_o}, {1'b1, 32'hCAFE_F00D, 2'b00, 16'd7});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Misaligned request
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0002;
        step();
        req_valid_i = 1'b0;
        chk("t4_no_ar", addr_r_valid_o, 0);
        chk("t4_rsp", {rsp_valid_o, rsp_data_o, rsp_resp_o, rsp_lat_o}, {1'b1, 32'h0, 2'b10, 16'd0});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Three-beat burst, all OKAY
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0100; addr_r_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        addr_r_ready_i = 1'b0;
        beat(32'h0000_00AA, 2'b00, 1'b0);
        chk("t5_drain", {r_ready_o, rsp_valid_o}, 2'b10);
        beat(32'h0000_00BB, 2'b00, 1'b0);
        beat(32'h0000_00CC, 2'b00, 1'b1);
        chk("t5_rsp", {rsp_valid_o, rsp_data_o, rsp_resp_o, rsp_lat_o}, {1'b1, 32'hAA, 2'b10, 16'd4});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Burst with DECERR on the middle beat
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0104; addr_r_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        addr_r_ready_i = 1'b0;
        beat(32'h0000_00AA, 2'b00, 1'b0);
        beat(32'h0000_00BB, 2'b11, 1'b0);
        beat(32'h0000_00CC, 2'b10, 1'b1);
        chk("t5_decerr", {rsp_valid_o, rsp_data_o, rsp_resp_o}, {1'b1, 32'hAA, 2'b11});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Response back-pressure with the next request already waiting
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0200; addr_r_ready_i = 1'b1;
        step();
        req_addr_i = 32'h8000_0300;
        step();
        addr_r_ready_i = 1'b0;
        beat(32'h1111_1111, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t6_hold", {rsp_valid_o, req_ready_o, addr_r_valid_o, rsp_data_o, rsp_resp_o, rsp_lat_o},
                {1'b1, 1'b0, 1'b0, 32'h1111_1111, 2'b00, 16'd2});
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("t6_released", {rsp_valid_o, req_ready_o}, 2'b01);
        addr_r_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        chk("t6_second_ar", {addr_r_valid_o, addr_r_addr_o}, {1'b1, 32'h8000_0300});
        step();
        addr_r_ready_i = 1'b0;
        beat(32'h2222_2222, 2'b00, 1'b1);
        chk("t6_second_rsp", {rsp_valid_o, rsp_data_o, rsp_resp_o, rsp_lat_o}, {1'b1, 32'h2222_2222, 2'b00, 16'd2});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("t6_done", {rsp_valid_o, req_ready_o}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
